blink_sequencer: RTL and testbench
==================================

// Module: blink_sequencer
// PURPOSE
//  Parametrised LED blink sequencer; successor of the fixed control FSM. Integrates on/off/gap
//  timers and the blink counter that were external, adds runtime-programmable timing, N output
//  channels with a mask, repeat mode and abort. Sits between the register/button front end and LED pins.
// PARAMETERS
//  CNT_W    8   width of blink count and blinks_left_out
//  TMR_W    16  width of on/off/gap timer loads and internal timer
//  CHANNELS 4   number of LED outputs
// PORTS
//  clock_in         in   1         single clock, all logic on rising edge
//  reset_in         in   1         asynchronous, active-low reset
//  start_in         in   1         start request, sampled in READY only
//  stop_in          in   1         abort, any state; wins over start_in
//  mode_in          in   1         0 single-shot, 1 repeat; latched at start
//  blink_count_in   in   CNT_W     blinks per burst; latched at start
//  on_time_in       in   TMR_W     ON timer load; latched at start
//  off_time_in      in   TMR_W     OFF timer load; latched at start
//  gap_time_in      in   TMR_W     post-burst gap timer load; latched at start
//  channel_mask_in  in   CHANNELS  channels driven during lit states; latched at start
//  led_out          out  CHANNELS  mask in ON/DEC, else 0
//  busy_out         out  1         1 in every state except READY
//  done_out         out  1         1-cycle pulse at burst completion
//  blinks_left_out  out  CNT_W     remaining blinks in current burst
//  state_out        out  3         current state encoding
// BEHAVIOUR
//  - Reset (reset_in=0): state READY, timer/count/latches 0; all outputs 0, immediately, mid-run too.
//  - Outputs decoded combinationally from state register and latched mask; no extra register stage.
//  - States: READY=000 LOAD=001 ON=010 DEC=011 OFF=100 GAP=101 DONE=110; 111 -> READY next edge.
//  - READY: start_in=1 & blink_count_in!=0 & stop_in=0 -> LOAD; latch all *_in config, count<=blink_count_in.
//    start_in with blink_count_in==0 ignored (stay READY, no done_out).
//  - LOAD (1 cycle): timer<=on_time -> ON.
//  - ON: timer==0 -> DEC, else timer-1. Lasts on_time+1 cycles.
//  - DEC (1 cycle, led still lit): count<=count-1; if count==1 -> GAP, timer<=gap_time;
//    else -> OFF, timer<=off_time.
//  - OFF: timer==0 -> ON with timer<=on_time, else timer-1. Lasts off_time+1 cycles.
//  - GAP: timer==0 -> single-shot: DONE; repeat: done_out=1 this cycle, count<=latched count,
//    timer<=on_time, -> ON. Else timer-1. Lasts gap_time+1 cycles.
//  - DONE (1 cycle): done_out=1 -> READY.
//  - Per blink: led high on_time+2 cycles, low off_time+1 (last blink: gap_time+1, +1 DONE).
//  - Timer loads of 0 legal: state lasts exactly 1 cycle. Timer never wraps; count never underflows.
//  - stop_in=1 in any non-READY state -> READY next edge; leds 0, no done_out; latches kept.
//  - start_in outside READY ignored; config input changes mid-burst have no effect until next start.
//  - blinks_left_out = count; 0 in READY after single-shot completion.
// TESTING
//  - Reset mid-ON (reset_in low 1 cycle) -> led_out=0, state_out=000, busy_out=0 same cycle; stays READY.
//  - count=3,on=2,off=1,gap=4,mask=4'b0101,mode 0 -> led 0101 x4, 0 x2, 0101 x4, 0 x2, 0101 x4,
//    0 x5, done_out 1 cycle; start->first lit cycle latency 2 edges.
//  - start with blink_count_in=0 -> stays READY, busy_out=0, done_out never 1.
//  - count=2,on=0,off=0,gap=0,mode 1 -> led pattern 2 on/1 off/2 on/1 off repeating; done_out pulses
//    every 6 cycles, at GAP exit; blinks_left_out reloads to 2.
//  - stop_in asserted during OFF of blink 2 of 5 -> READY next edge, led 0, no done_out; re-start works.
//  - start_in pulsed and on_time_in changed during ON -> no restart, timing unchanged; state 111 forced -> READY.

Source files
------------

// File: rtl/blink_sequencer.sv
// Parametrised LED blink sequencer: programmable on/off/gap timing, blink bursts,
// channel mask, single-shot or repeat mode, and abort.
module blink_sequencer #(
    parameter int CNT_W    = 8,
    parameter int TMR_W    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic                mode_in,
    input  logic [CNT_W-1:0]    blink_count_in,
    input  logic [TMR_W-1:0]    on_time_in,
    input  logic [TMR_W-1:0]    off_time_in,
    input  logic [TMR_W-1:0]    gap_time_in,
    input  logic [CHANNELS-1:0] channel_mask_in,
    output logic [CHANNELS-1:0] led_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [CNT_W-1:0]    blinks_left_out,
    output logic [2:0]          state_out
);

    typedef enum logic [2:0] {
        ST_READY = 3'b000,
        ST_LOAD  = 3'b001,
        ST_ON    = 3'b010,
        ST_DEC   = 3'b011,
        ST_OFF   = 3'b100,
        ST_GAP   = 3'b101,
        ST_DONE  = 3'b110
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                load_cfg;

    logic                mode_q;
    logic [CNT_W-1:0]    count_cfg_q;
    logic [TMR_W-1:0]    on_q, off_q, gap_q;
    logic [CHANNELS-1:0] mask_q;

    logic                timer_zero;
    assign timer_zero = (timer_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_READY;
            timer_q     <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            count_cfg_q <= '0;
            on_q        <= '0;
            off_q       <= '0;
            gap_q       <= '0;
            mask_q      <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            if (load_cfg) begin
                mode_q      <= mode_in;
                count_cfg_q <= blink_count_in;
                on_q        <= on_time_in;
                off_q       <= off_time_in;
                gap_q       <= gap_time_in;
                mask_q      <= channel_mask_in;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        load_cfg = 1'b0;
        case (state_q)
            ST_READY: begin
                if (start_in && !stop_in && (blink_count_in != '0)) begin
                    state_d  = ST_LOAD;
                    load_cfg = 1'b1;
                    count_d  = blink_count_in;
                end
            end
            ST_LOAD: begin
                timer_d = on_q;
                state_d = ST_ON;
            end
            ST_ON: begin
                if (timer_zero) state_d = ST_DEC;
                else            timer_d = timer_q - TMR_W'(1);
            end
            ST_DEC: begin
                if (count_q != '0) count_d = count_q - CNT_W'(1);
                if (count_q <= CNT_W'(1)) begin
                    state_d = ST_GAP;
                    timer_d = gap_q;
                end else begin
                    state_d = ST_OFF;
                    timer_d = off_q;
                end
            end
            ST_OFF: begin
                if (timer_zero) begin
                    state_d = ST_ON;
                    timer_d = on_q;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (!timer_zero) begin
                    timer_d = timer_q - TMR_W'(1);
                end else if (mode_q) begin
                    state_d = ST_ON;
                    timer_d = on_q;
                    count_d = count_cfg_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_READY;
            default: state_d = ST_READY;
        endcase

        // Abort overrides everything; timer and count simply hold.
        if (stop_in && (state_q != ST_READY)) begin
            state_d = ST_READY;
            timer_d = timer_q;
            count_d = count_q;
        end
    end

    always_comb begin
        led_out         = ((state_q == ST_ON) || (state_q == ST_DEC)) ? mask_q : '0;
        busy_out        = (state_q != ST_READY);
        done_out        = (state_q == ST_DONE) ||
                          ((state_q == ST_GAP) && timer_zero && mode_q && !stop_in);
        blinks_left_out = count_q;
        state_out       = state_q;
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized self-checking bench for blink_sequencer; expected per-cycle traces are
// generated from the blink timing rules (LOAD, then on+2 lit / off+1 dark per blink).
module tb_blink_sequencer;

    localparam int CNT_W = 8;
    localparam int TMR_W = 16;
    localparam int CH    = 4;

    logic             clock_in = 1'b0;
    logic             reset_in;
    logic             start_in, stop_in, mode_in;
    logic [CNT_W-1:0] blink_count_in;
    logic [TMR_W-1:0] on_time_in, off_time_in, gap_time_in;
    logic [CH-1:0]    channel_mask_in;
    logic [CH-1:0]    led_out;
    logic             busy_out, done_out;
    logic [CNT_W-1:0] blinks_left_out;
    logic [2:0]       state_out;

    blink_sequencer #(.CNT_W(CNT_W), .TMR_W(TMR_W), .CHANNELS(CH)) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .stop_in         (stop_in),
        .mode_in         (mode_in),
        .blink_count_in  (blink_count_in),
        .on_time_in      (on_time_in),
        .off_time_in     (off_time_in),
        .gap_time_in     (gap_time_in),
        .channel_mask_in (channel_mask_in),
        .led_out         (led_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .blinks_left_out (blinks_left_out),
        .state_out       (state_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [2:0]       st;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] left;
        logic [CH-1:0]    led;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        return obs_t'{state_out, busy_out, done_out, blinks_left_out, led_out};
    endfunction

    task automatic push(input logic [2:0] st, input logic dn, input int left, input logic [CH-1:0] led);
        exp_q.push_back(obs_t'{st, (st != 3'd0), dn, CNT_W'(left), led});
    endtask

    // Expected cycle-by-cycle trace of one start, derived from the blink timing rules.
    task automatic build(input int cnt, input int on, input int off, input int gap,
                         input logic [CH-1:0] mask, input bit mode, input int bursts);
        exp_q.delete();
        push(3'd1, 1'b0, cnt, '0);
        for (int b = 0; b < bursts; b++) begin
            for (int i = 0; i < cnt; i++) begin
                for (int t = 0; t <= on; t++) push(3'd2, 1'b0, cnt - i, mask);
                push(3'd3, 1'b0, cnt - i, mask);
                if (i < cnt - 1) begin
                    for (int t = 0; t <= off; t++) push(3'd4, 1'b0, cnt - i - 1, '0);
                end else begin
                    for (int t = 0; t <= gap; t++) push(3'd5, mode && (t == gap), 0, '0);
                end
            end
        end
        if (!mode) begin
            push(3'd6, 1'b1, 0, '0);
            push(3'd0, 1'b0, 0, '0);
            push(3'd0, 1'b0, 0, '0);
        end
    endtask

    task automatic drive_noise();
        start_in        = 1'($urandom_range(0, 1));
        stop_in         = 1'b0;
        mode_in         = 1'($urandom_range(0, 1));
        blink_count_in  = CNT_W'($urandom);
        on_time_in      = TMR_W'($urandom);
        off_time_in     = TMR_W'($urandom);
        gap_time_in     = TMR_W'($urandom);
        channel_mask_in = CH'($urandom);
    endtask

    // stop_at: index after which stop_in is raised; -1 none, -2 end of trace.
    task automatic run(input string tag, input int cnt, input int on, input int off, input int gap,
                       input logic [CH-1:0] mask, input bit mode, input int bursts, input int stop_at);
        int  stop_idx;
        bit  stopped;
        @(negedge clock_in);
        start_in        = 1'b1;
        stop_in         = 1'b0;
        mode_in         = mode;
        blink_count_in  = CNT_W'(cnt);
        on_time_in      = TMR_W'(on);
        off_time_in     = TMR_W'(off);
        gap_time_in     = TMR_W'(gap);
        channel_mask_in = mask;
        build(cnt, on, off, gap, mask, mode, bursts);
        stop_idx = (stop_at == -2) ? exp_q.size() - 1 : stop_at;
        stopped  = 1'b0;
        for (int k = 0; k < exp_q.size() && !stopped; k++) begin
            @(negedge clock_in);
            check($sformatf("%s[%0d]", tag, k), 32'(observe()), 32'(exp_q[k]));
            if (k == stop_idx) begin
                start_in = 1'b0;
                stop_in  = 1'b1;
                @(negedge clock_in);
                stop_in = 1'b0;
                check($sformatf("%s_stop", tag),
                      32'({state_out, busy_out, done_out, led_out}), 32'(0));
                @(negedge clock_in);
                check($sformatf("%s_idle", tag),
                      32'({state_out, busy_out, done_out, led_out}), 32'(0));
                stopped = 1'b1;
            end else if (exp_q[k].st == 3'd0 || exp_q[k].st == 3'd6) begin
                start_in = 1'b0;
            end else begin
                drive_noise();
            end
        end
        start_in = 1'b0;
        stop_in  = 1'b0;
    endtask

    initial begin
        reset_in        = 1'b0;
        start_in        = 1'b0;
        stop_in         = 1'b0;
        mode_in         = 1'b0;
        blink_count_in  = '0;
        on_time_in      = '0;
        off_time_in     = '0;
        gap_time_in     = '0;
        channel_mask_in = '0;
        @(negedge clock_in);
        check("reset", 32'(observe()), 32'(0));
        reset_in = 1'b1;

        run("single", 3, 2, 1, 4, 4'b0101, 1'b0, 1, -1);
        run("repeat", 2, 0, 0, 0, 4'b1111, 1'b1, 3, -2);
        run("stop5", 5, 1, 2, 1, 4'b1010, 1'b0, 1, 10);

        for (int r = 0; r < 20; r++) begin
            int  cnt, on, off, gap, sa;
            bit  md;
            cnt = $urandom_range(1, 4);
            on  = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            gap = $urandom_range(0, 3);
            md  = 1'($urandom_range(0, 1));
            if (md)                           sa = -2;
            else if ($urandom_range(0, 3) == 0) sa = $urandom_range(0, 5);
            else                              sa = -1;
            run($sformatf("rnd%0d", r), cnt, on, off, gap, CH'($urandom), md, md ? 2 : 1, sa);
        end

        // Zero blink count is ignored.
        @(negedge clock_in);
        start_in       = 1'b1;
        blink_count_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_in);
            check($sformatf("zero_cnt[%0d]", i), 32'({state_out, busy_out, done_out}), 32'(0));
        end
        start_in = 1'b0;

        // Stop wins over start in READY.
        start_in       = 1'b1;
        stop_in        = 1'b1;
        blink_count_in = 8'd3;
        @(negedge clock_in);
        check("stop_wins", 32'({state_out, busy_out}), 32'(0));
        start_in = 1'b0;
        stop_in  = 1'b0;

        // Asynchronous reset in the middle of ON.
        start_in        = 1'b1;
        mode_in         = 1'b0;
        blink_count_in  = 8'd3;
        on_time_in      = 16'd5;
        off_time_in     = 16'd1;
        gap_time_in     = 16'd1;
        channel_mask_in = 4'b1111;
        @(negedge clock_in);
        start_in = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
        check("pre_reset_lit", 32'({state_out, led_out}), 32'({3'd2, 4'b1111}));
        #2 reset_in = 1'b0;
        #1 check("async_reset", 32'(observe()), 32'(0));
        @(negedge clock_in);
        reset_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_in);
            check($sformatf("post_reset[%0d]", i), 32'(observe()), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
